bram_rd_seq: RTL and testbench

Parametrised read-address sequencer for the dual/multi-port weight and activation BRAMs. On a start command it walks a programmable address window, interleaving consecutive addresses across NUM_PORTS read ports and holding each address for a programmable number of cycles. It also drives constant read-only controls (we=0, din=0), tracks BRAM read latency to flag valid data, and supports one-shot or looping operation with abort. It replaces the fixed two-port, fixed hold-of-4, free-running address counter used for BRAM bring-up.

---
 rtl/bram_rd_seq.sv | 181 ++++++++++++++++++
 tb/tb_bram_rd_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bram_rd_seq.sv
// bram_rd_seq: read-address sequencer for the weight/activation BRAMs.
//
// A start command latches a window (base_addr, length), a hold count and a
// loop flag. The window is then walked in beats of NUM_PORTS addresses:
//   - beat k puts base+k*NUM_PORTS+p on port p;
//   - each beat lasts hold_cycles+1 cycles;
//   - enables pulse only on the first cycle of a beat.
// After the last beat the sequencer either restarts the window or drains
// RD_LAT cycles so in-flight reads complete, and then pulses done_o.
//
// Ports:
//   clk_a, rst_n       clock, async active-low reset
//   start, stop        start pulse (honoured in IDLE), abort (honoured in RUN)
//   base_addr, length  address window; length==0 completes immediately
//   hold_cycles        extra cycles each beat is held
//   loop_en            restart at base_addr after the last beat
//   addr_o, ena_o      per-port read address / enable (port p at [p*ADDR_W +: ADDR_W])
//   we_o, din_o        tied to zero (read-only use)
//   rd_valid_o         ena_o delayed RD_LAT cycles: BRAM dout valid
//   busy_o, done_o     active flag, one-cycle completion pulse
module bram_rd_seq #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 1280,
    parameter int NUM_PORTS = 2,
    parameter int HOLD_W    = 4,
    parameter int RD_LAT    = 2
) (
    input  logic                          clk_a,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W-1:0]             length,
    input  logic [HOLD_W-1:0]             hold_cycles,
    input  logic                          loop_en,
    output logic [NUM_PORTS*ADDR_W-1:0]   addr_o,
    output logic [NUM_PORTS-1:0]          ena_o,
    output logic [NUM_PORTS-1:0]          we_o,
    output logic [NUM_PORTS*DATA_W-1:0]   din_o,
    output logic [NUM_PORTS-1:0]          rd_valid_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int IW = ADDR_W + 1;          // index width: one spare bit so idx+NUM_PORTS never overflows
    localparam int DW = $clog2(RD_LAT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                              r_state;
    logic [ADDR_W-1:0]                   r_base;
    logic [ADDR_W-1:0]                   r_len;
    logic [HOLD_W-1:0]                   r_hold;
    logic                                r_loop;
    logic [IW-1:0]                       r_idx;    // window index of port 0 in current beat
    logic [HOLD_W-1:0]                   r_hcnt;
    logic [DW-1:0]                       r_dcnt;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]    r_addr;
    logic [NUM_PORTS-1:0]                r_ena;
    logic                                r_busy;
    logic                                r_done;
    logic [RD_LAT-1:0][NUM_PORTS-1:0]    r_vld_pipe;

    logic [IW-1:0]                       w_nidx;
    logic                                w_last;
    logic                                w_beat_end;
    logic [IW-1:0]                       w_tidx;
    logic [ADDR_W-1:0]                   w_tbase;
    logic [ADDR_W-1:0]                   w_tlen;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]    w_addr;
    logic [NUM_PORTS-1:0]                w_ena;

    // Address/enable of the beat that would be loaded next. From IDLE the
    // live inputs are used since they are being latched in the same edge;
    // a finished window wraps the index to 0 (loop restart).
    always_comb begin
        w_nidx     = r_idx + IW'(NUM_PORTS);
        w_last     = (w_nidx >= {1'b0, r_len});
        w_beat_end = (r_hcnt == r_hold);
        w_tidx     = (r_state == S_IDLE || w_last) ? '0 : w_nidx;
        w_tbase    = (r_state == S_IDLE) ? base_addr : r_base;
        w_tlen     = (r_state == S_IDLE) ? length    : r_len;
        w_addr     = '0;
        w_ena      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_addr[p] = w_tbase + w_tidx[ADDR_W-1:0] + ADDR_W'(p);
            w_ena[p]  = ((w_tidx + IW'(p)) < {1'b0, w_tlen});
        end
    end

    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_hold  <= '0;
            r_loop  <= 1'b0;
            r_idx   <= '0;
            r_hcnt  <= '0;
            r_dcnt  <= '0;
            r_addr  <= '0;
            r_ena   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= length;
                        r_hold <= hold_cycles;
                        r_loop <= loop_en;
                        if (length == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_idx   <= '0;
                            r_hcnt  <= '0;
                            r_addr  <= w_addr;
                            r_ena   <= w_ena;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop || (w_beat_end && w_last && !r_loop)) begin
                        // abort wins over loop restart; addresses stay frozen
                        r_state <= S_DRAIN;
                        r_ena   <= '0;
                        r_dcnt  <= '0;
                    end else if (!w_beat_end) begin
                        r_hcnt <= r_hcnt + 1'b1;
                        r_ena  <= '0;
                    end else begin
                        r_idx  <= w_tidx;
                        r_hcnt <= '0;
                        r_addr <= w_addr;
                        r_ena  <= w_ena;
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == DW'(RD_LAT - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ena   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency tracker: enables shifted RD_LAT cycles.
    always_ff @(posedge clk_a or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= r_ena;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    assign addr_o     = r_addr;
    assign ena_o      = r_ena;
    assign we_o       = '0;
    assign din_o      = '0;
    assign rd_valid_o = r_vld_pipe[RD_LAT-1];
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule

// File: tb/tb_bram_rd_seq.sv
// Directed bench for bram_rd_seq (NUM_PORTS=2, RD_LAT=2, ADDR_W=12).
// Cycle 0 is the cycle in which start is high; outputs are sampled on
// the falling edge of each cycle and compared against hand-written tables.
module tb_bram_rd_seq;

    logic          clk_a = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [11:0]   base_addr = '0;
    logic [11:0]   length = '0;
    logic [3:0]    hold_cycles = '0;
    logic          loop_en = 1'b0;
    logic [23:0]   addr_o;
    logic [1:0]    ena_o;
    logic [1:0]    we_o;
    logic [2559:0] din_o;
    logic [1:0]    rd_valid_o;
    logic          busy_o;
    logic          done_o;

    bram_rd_seq #(.ADDR_W(12), .DATA_W(1280), .NUM_PORTS(2), .HOLD_W(4), .RD_LAT(2)) dut (
        .clk_a(clk_a), .rst_n(rst_n), .start(start), .stop(stop),
        .base_addr(base_addr), .length(length), .hold_cycles(hold_cycles), .loop_en(loop_en),
        .addr_o(addr_o), .ena_o(ena_o), .we_o(we_o), .din_o(din_o),
        .rd_valid_o(rd_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_a = ~clk_a;

    typedef struct {
        int         tid;
        int         cyc;
        logic [11:0] a0, a1;
        logic [1:0]  ena, rdv;
        logic        busy, done;
    } vec_t;

    vec_t        vq[$];
    logic [29:0] tr [0:31];
    int          total = 0;
    int          bad = 0;

    task automatic add(input int t, input int c, input logic [11:0] a0, input logic [11:0] a1,
                       input logic [1:0] e, input logic [1:0] r, input logic b, input logic d);
        vec_t v;
        v.tid = t; v.cyc = c; v.a0 = a0; v.a1 = a1; v.ena = e; v.rdv = r; v.busy = b; v.done = d;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    function automatic logic [29:0] snap();
        return {addr_o, ena_o, rd_valid_o, busy_o, done_o};
    endfunction

    // Start a command at cycle 0 then trace n cycles. Inputs are scrambled
    // after the start edge so any dependency on live inputs shows up.
    task automatic run(input logic [11:0] b, input logic [11:0] l, input logic [3:0] h,
                       input logic lp, input int n, input int stop_c, input int start_c);
        @(negedge clk_a);
        base_addr = b; length = l; hold_cycles = h; loop_en = lp; start = 1'b1;
        tr[0] = snap();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk_a);
            start       = (c == start_c);
            stop        = (c == stop_c);
            base_addr   = b ^ 12'h5A5;
            length      = l + 12'd7;
            hold_cycles = h + 4'd2;
            loop_en     = ~lp;
            tr[c] = snap();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check(input int t);
        foreach (vq[i]) begin
            if (vq[i].tid == t) begin
                chk($sformatf("t%0d_c%0d", t, vq[i].cyc), {34'd0, tr[vq[i].cyc]},
                    {34'd0, vq[i].a1, vq[i].a0, vq[i].ena, vq[i].rdv, vq[i].busy, vq[i].done});
            end
        end
    endtask

    initial begin
        logic seen_done;
        // t1: base 0x010, len 8, hold 3; a stray start at cycle 4 must be ignored
        add(1, 0, 12'h000, 12'h000, 2'b00, 2'b00, 0, 0);
        add(1, 1, 12'h010, 12'h011, 2'b11, 2'b00, 1, 0);
        add(1, 2, 12'h010, 12'h011, 2'b00, 2'b00, 1, 0);
        add(1, 3, 12'h010, 12'h011, 2'b00, 2'b11, 1, 0);
        add(1, 4, 12'h010, 12'h011, 2'b00, 2'b00, 1, 0);
        add(1, 5, 12'h012, 12'h013, 2'b11, 2'b00, 1, 0);
        add(1, 7, 12'h012, 12'h013, 2'b00, 2'b11, 1, 0);
        add(1, 8, 12'h012, 12'h013, 2'b00, 2'b00, 1, 0);
        add(1, 9, 12'h014, 12'h015, 2'b11, 2'b00, 1, 0);
        add(1, 11, 12'h014, 12'h015, 2'b00, 2'b11, 1, 0);
        add(1, 13, 12'h016, 12'h017, 2'b11, 2'b00, 1, 0);
        add(1, 15, 12'h016, 12'h017, 2'b00, 2'b11, 1, 0);
        add(1, 16, 12'h016, 12'h017, 2'b00, 2'b00, 1, 0);
        add(1, 17, 12'h016, 12'h017, 2'b00, 2'b00, 1, 0);
        add(1, 18, 12'h016, 12'h017, 2'b00, 2'b00, 1, 0);
        add(1, 19, 12'h016, 12'h017, 2'b00, 2'b00, 0, 1);
        add(1, 20, 12'h016, 12'h017, 2'b00, 2'b00, 0, 0);
        // t2: base 0x100, len 5, hold 0 -> partial last beat
        add(2, 1, 12'h100, 12'h101, 2'b11, 2'b00, 1, 0);
        add(2, 2, 12'h102, 12'h103, 2'b11, 2'b00, 1, 0);
        add(2, 3, 12'h104, 12'h105, 2'b01, 2'b11, 1, 0);
        add(2, 4, 12'h104, 12'h105, 2'b00, 2'b11, 1, 0);
        add(2, 5, 12'h104, 12'h105, 2'b00, 2'b01, 1, 0);
        add(2, 6, 12'h104, 12'h105, 2'b00, 2'b00, 0, 1);
        add(2, 7, 12'h104, 12'h105, 2'b00, 2'b00, 0, 0);
        // t3: address wrap at top of space
        add(3, 1, 12'hFFE, 12'hFFF, 2'b11, 2'b00, 1, 0);
        add(3, 2, 12'h000, 12'h001, 2'b11, 2'b00, 1, 0);
        add(3, 3, 12'h000, 12'h001, 2'b00, 2'b11, 1, 0);
        add(3, 4, 12'h000, 12'h001, 2'b00, 2'b11, 1, 0);
        add(3, 5, 12'h000, 12'h001, 2'b00, 2'b00, 0, 1);
        // t4: loop, len 4, hold 1, stop at cycle 10
        add(4, 1, 12'h200, 12'h201, 2'b11, 2'b00, 1, 0);
        add(4, 3, 12'h202, 12'h203, 2'b11, 2'b11, 1, 0);
        add(4, 4, 12'h202, 12'h203, 2'b00, 2'b00, 1, 0);
        add(4, 5, 12'h200, 12'h201, 2'b11, 2'b11, 1, 0);
        add(4, 7, 12'h202, 12'h203, 2'b11, 2'b11, 1, 0);
        add(4, 9, 12'h200, 12'h201, 2'b11, 2'b11, 1, 0);
        add(4, 10, 12'h200, 12'h201, 2'b00, 2'b00, 1, 0);
        add(4, 11, 12'h200, 12'h201, 2'b00, 2'b11, 1, 0);
        add(4, 12, 12'h200, 12'h201, 2'b00, 2'b00, 1, 0);
        add(4, 13, 12'h200, 12'h201, 2'b00, 2'b00, 0, 1);
        add(4, 14, 12'h200, 12'h201, 2'b00, 2'b00, 0, 0);
        // t5: zero length completes at once, address retained
        add(5, 1, 12'h200, 12'h201, 2'b00, 2'b00, 0, 1);
        add(5, 2, 12'h200, 12'h201, 2'b00, 2'b00, 0, 0);

        repeat (3) @(negedge clk_a);
        rst_n = 1'b1;

        run(12'h010, 12'd8, 4'd3, 1'b0, 21, -1, 4);
        check(1);
        chk("we_zero", {62'd0, we_o}, 64'd0);
        chk("din_zero", {63'd0, |din_o}, 64'd0);
        run(12'h100, 12'd5, 4'd0, 1'b0, 8, -1, -1);
        check(2);
        run(12'hFFE, 12'd4, 4'd0, 1'b0, 7, -1, -1);
        check(3);
        run(12'h200, 12'd4, 4'd1, 1'b1, 15, 10, -1);
        check(4);
        run(12'h300, 12'd0, 4'd0, 1'b0, 3, -1, -1);
        check(5);

        // Reset in the middle of a run: outputs clear without a clock edge,
        // and no done pulse follows.
        @(negedge clk_a);
        base_addr = 12'h010; length = 12'd8; hold_cycles = 4'd3; loop_en = 1'b0; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_a);
            start = 1'b0;
        end
        chk("pre_rst_busy", {63'd0, busy_o}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {34'd0, snap()}, 64'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_a);
            if (done_o) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_a);
            if (done_o) seen_done = 1'b1;
        end
        chk("no_done_after_rst", {63'd0, seen_done}, 64'd0);
        run(12'h100, 12'd5, 4'd0, 1'b0, 8, -1, -1);
        check(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
